// File: rtl/quiz_round_ctrl_if.sv
// Bundle between the debounced key/switch front end and the quiz round
// controller. The front end drives the player-side inputs. The controller
// drives the registered display and status outputs.
//
// Handshake semantics: there is no valid/ready pair and no back-pressure.
// start and submit are single-cycle strobes that are already edge-detected.
// A submit counts as accepted only when state==QUESTION and pause==0;
// in every other case it is silently dropped. answer is sampled only in
// the accepting cycle. expected must stay stable for the whole QUESTION
// state. result_valid is a one-cycle strobe with no acknowledge, and
// result_correct holds its value until the next judgement.
interface quiz_round_ctrl_if #(
  parameter int ROUNDS  = 8,
  parameter int ANS_W   = 9,
  parameter int SCORE_W = 8
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic               start;
  logic               submit;
  logic [ANS_W-1:0]   answer;
  logic [ANS_W-1:0]   expected;
  logic               pause;
  logic [2:0]         state;
  logic [RW-1:0]      round_idx;
  logic [5:0]         minutes;
  logic [5:0]         seconds;
  logic               rem;
  logic [SCORE_W-1:0] score;
  logic               result_valid;
  logic               result_correct;
  logic               done;

  modport master (
    output start, submit, answer, expected, pause,
    input  state, round_idx, minutes, seconds, rem, score,
           result_valid, result_correct, done
  );

  modport slave (
    input  start, submit, answer, expected, pause,
    output state, round_idx, minutes, seconds, rem, score,
           result_valid, result_correct, done
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// HexaQuiz round controller. It sequences ROUNDS questions, each with an
// mm:ss countdown, judges the submitted answers, and keeps a saturating
// score that includes a time bonus. Every output comes from a register.
module quiz_round_ctrl #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int ROUNDS      = 8,
  parameter int ANS_W       = 9,
  parameter int SCORE_W     = 8,
  parameter int TIME_SECS   = 60,
  parameter int REVEAL_SECS = 2
) (
  input logic              clk,
  input logic              reset,
  quiz_round_ctrl_if.slave bus
);
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int REV_W = $clog2(REVEAL_SECS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_QUESTION = 3'd2,
    S_JUDGE    = 3'd3,
    S_REVEAL   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         mm_q, mm_d;
  logic [5:0]         ss_q, ss_d;
  logic [11:0]        tot_q, tot_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic [RW-1:0]      round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               rem_q, rem_d;
  logic               verdict_q, verdict_d;
  logic               res_valid_q, res_valid_d;
  logic               res_correct_q, res_correct_d;
  logic               done_q, done_d;

  logic               timing_run;
  logic               tick;
  logic               accept;
  logic               expire;
  logic [1:0]         bonus;
  logic [SCORE_W:0]   score_sum;

  // One-second strobe. The prescaler runs only while a countdown or a
  // reveal hold is active, and it freezes while pause is high.
  always_comb begin
    timing_run = (state_q == S_QUESTION) || (state_q == S_REVEAL);
    tick       = timing_run && !bus.pause && (cnt_q == CNT_W'(CLK_HZ - 1));
    accept     = (state_q == S_QUESTION) && bus.submit && !bus.pause;
    expire     = (state_q == S_QUESTION) && tick && (tot_q == 12'd1);
  end

  // Next-state logic for the round FSM, the countdown, the prescaler and the scoring.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mm_d          = mm_q;
    ss_d          = ss_q;
    tot_d         = tot_q;
    rev_d         = rev_q;
    round_d       = round_q;
    score_d       = score_q;
    rem_d         = rem_q;
    verdict_d     = verdict_q;
    res_valid_d   = 1'b0;
    res_correct_d = res_correct_q;
    done_d        = done_q;
    bonus         = 2'd0;
    score_sum     = '0;

    if (!timing_run) begin
      cnt_d = '0;
    end else if (!bus.pause) begin
      cnt_d = (cnt_q == CNT_W'(CLK_HZ - 1)) ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_LOAD;
          score_d       = '0;
          round_d       = '0;
          done_d        = 1'b0;
          res_correct_d = 1'b0;
        end
      end
      S_LOAD: begin
        mm_d    = 6'(TIME_SECS / 60);
        ss_d    = 6'(TIME_SECS % 60);
        tot_d   = 12'(TIME_SECS);
        rem_d   = 1'b0;
        state_d = S_QUESTION;
      end
      S_QUESTION: begin
        // The clock keeps running on the submit cycle. A submit still
        // beats the expiring tick, so rem stays low in that case.
        if (tick) begin
          tot_d = tot_q - 12'd1;
          if (ss_q == 6'd0) begin
            ss_d = 6'd59;
            mm_d = mm_q - 6'd1;
          end else begin
            ss_d = ss_q - 6'd1;
          end
        end
        if (accept) begin
          verdict_d = (bus.answer == bus.expected);
          state_d   = S_JUDGE;
        end else if (expire) begin
          verdict_d = 1'b0;
          rem_d     = 1'b1;
          state_d   = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (verdict_q) begin
          bonus = (tot_q >= 12'(TIME_SECS / 2)) ? 2'd2 : 2'd1;
        end
        score_sum     = {1'b0, score_q} + (SCORE_W + 1)'(bonus);
        score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        res_valid_d   = 1'b1;
        res_correct_d = verdict_q;
        state_d       = S_REVEAL;
      end
      S_REVEAL: begin
        if (tick) begin
          if (rev_q == REV_W'(REVEAL_SECS - 1)) begin
            rev_d = '0;
            if (round_q == RW'(ROUNDS - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              round_d = round_q + RW'(1);
              state_d = S_LOAD;
            end
          end else begin
            rev_d = rev_q + REV_W'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d       = S_LOAD;
          score_d       = '0;
          round_d       = '0;
          done_d        = 1'b0;
          res_correct_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register. Reset is synchronous and overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mm_q          <= '0;
      ss_q          <= '0;
      tot_q         <= '0;
      rev_q         <= '0;
      round_q       <= '0;
      score_q       <= '0;
      rem_q         <= 1'b0;
      verdict_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_correct_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mm_q          <= mm_d;
      ss_q          <= ss_d;
      tot_q         <= tot_d;
      rev_q         <= rev_d;
      round_q       <= round_d;
      score_q       <= score_d;
      rem_q         <= rem_d;
      verdict_q     <= verdict_d;
      res_valid_q   <= res_valid_d;
      res_correct_q <= res_correct_d;
      done_q        <= done_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.round_idx      = round_q;
  assign bus.minutes        = mm_q;
  assign bus.seconds        = ss_q;
  assign bus.rem            = rem_q;
  assign bus.score          = score_q;
  assign bus.result_valid   = res_valid_q;
  assign bus.result_correct = res_correct_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl. Instance A uses ROUNDS=2 and SCORE_W=8.
// Instance B uses ROUNDS=3 and SCORE_W=2 so that score saturation shows up.
// Both instances share the input stimulus, and start goes only to the
// instance selected by sel. The model counts elapsed unpaused cycles in the
// question and derives the remaining time, the bonus and the score from that.
module tb_quiz_round_ctrl;
  localparam int CLK_HZ      = 10;
  localparam int TIME_SECS   = 5;
  localparam int REVEAL_SECS = 1;
  localparam int ANS_W       = 9;

  logic clk = 1'b0;
  logic reset;
  logic start, submit, pause, sel;
  logic [ANS_W-1:0] answer, expected;

  always #5 clk = ~clk;

  quiz_round_ctrl_if #(.ROUNDS(2), .ANS_W(ANS_W), .SCORE_W(8)) if_a ();
  quiz_round_ctrl_if #(.ROUNDS(3), .ANS_W(ANS_W), .SCORE_W(2)) if_b ();

  assign if_a.start    = start & ~sel;
  assign if_b.start    = start & sel;
  assign if_a.submit   = submit;
  assign if_b.submit   = submit;
  assign if_a.answer   = answer;
  assign if_b.answer   = answer;
  assign if_a.expected = expected;
  assign if_b.expected = expected;
  assign if_a.pause    = pause;
  assign if_b.pause    = pause;

  quiz_round_ctrl #(.CLK_HZ(CLK_HZ), .ROUNDS(2), .ANS_W(ANS_W), .SCORE_W(8),
                    .TIME_SECS(TIME_SECS), .REVEAL_SECS(REVEAL_SECS))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));

  quiz_round_ctrl #(.CLK_HZ(CLK_HZ), .ROUNDS(3), .ANS_W(ANS_W), .SCORE_W(2),
                    .TIME_SECS(TIME_SECS), .REVEAL_SECS(REVEAL_SECS))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  // Observed outputs of whichever instance is under test
  logic [2:0] o_state;
  logic [7:0] o_round, o_score;
  logic [5:0] o_min, o_sec;
  logic       o_rem, o_rv, o_rc, o_done;

  always_comb begin
    if (sel) begin
      o_state = if_b.state;          o_round = 8'(if_b.round_idx);
      o_score = 8'(if_b.score);      o_min   = if_b.minutes;
      o_sec   = if_b.seconds;        o_rem   = if_b.rem;
      o_rv    = if_b.result_valid;   o_rc    = if_b.result_correct;
      o_done  = if_b.done;
    end else begin
      o_state = if_a.state;          o_round = 8'(if_a.round_idx);
      o_score = 8'(if_a.score);      o_min   = if_a.minutes;
      o_sec   = if_a.seconds;        o_rem   = if_a.rem;
      o_rv    = if_a.result_valid;   o_rc    = if_a.result_correct;
      o_done  = if_a.done;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int m_score, m_round, rounds_n, score_max;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string ctx);
    chk({ctx, "_state"}, 32'(o_state), 0);
    chk({ctx, "_round"}, 32'(o_round), 0);
    chk({ctx, "_min"},   32'(o_min),   0);
    chk({ctx, "_sec"},   32'(o_sec),   0);
    chk({ctx, "_rem"},   32'(o_rem),   0);
    chk({ctx, "_score"}, 32'(o_score), 0);
    chk({ctx, "_rv"},    32'(o_rv),    0);
    chk({ctx, "_rc"},    32'(o_rc),    0);
    chk({ctx, "_done"},  32'(o_done),  0);
  endtask

  // Pulse start from IDLE or DONE and follow LOAD into the first QUESTION cycle
  task automatic begin_game();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0;
    m_round = 0;
    chk("load_state", 32'(o_state), 1);
    chk("load_score", 32'(o_score), 0);
    chk("load_round", 32'(o_round), 0);
    chk("load_done",  32'(o_done),  0);
    chk("load_rc",    32'(o_rc),    0);
    step();
    chk("q0_state", 32'(o_state), 2);
    chk("q0_min",   32'(o_min),   TIME_SECS / 60);
    chk("q0_sec",   32'(o_sec),   TIME_SECS % 60);
    chk("q0_rem",   32'(o_rem),   0);
  endtask

  // Play one question, starting from its first QUESTION cycle.
  // submit_at is the number of unpaused cycles before the submit; a negative
  // or too-late value means no submit. The pause window is given in raw cycles.
  task automatic play_round(input logic [ANS_W-1:0] exp_val, input int submit_at,
                            input bit right, input int pause_at, input int pause_len);
    int act, cyc, r, bonus;
    bit subm, tout, corr, paused;
    act = 0; cyc = 0; subm = 0; tout = 0; corr = 0;
    expected = exp_val;
    while (!subm && !tout) begin
      chk("q_state", 32'(o_state), 2);
      chk("q_sec",   32'(o_sec),   (TIME_SECS - act / CLK_HZ) % 60);
      paused = (cyc >= pause_at) && (cyc < pause_at + pause_len);
      pause  = paused;
      if (paused && cyc == pause_at) begin
        submit = 1'b1;
        answer = expected;
      end else if (!paused && act == submit_at) begin
        submit = 1'b1;
        answer = right ? expected : expected ^ ANS_W'($urandom_range(1, 511));
        subm   = 1'b1;
        corr   = right;
      end
      step();
      submit = 1'b0;
      if (!subm) begin
        if (!paused) act++;
        if (act == TIME_SECS * CLK_HZ) tout = 1'b1;
      end
      cyc++;
    end
    pause = 1'b0;
    r = subm ? TIME_SECS - (act + 1) / CLK_HZ : 0;
    chk("judge_state", 32'(o_state), 3);
    chk("judge_rem",   32'(o_rem),   tout ? 1 : 0);
    chk("judge_sec",   32'(o_sec),   r % 60);
    chk("judge_min",   32'(o_min),   r / 60);
    bonus = !corr ? 0 : ((r >= TIME_SECS / 2) ? 2 : 1);
    m_score = (m_score + bonus > score_max) ? score_max : m_score + bonus;
    step();
    chk("rev_state", 32'(o_state), 4);
    chk("rev_rv",    32'(o_rv),    1);
    chk("rev_rc",    32'(o_rc),    corr);
    chk("rev_score", 32'(o_score), m_score);
    for (int i = 1; i < REVEAL_SECS * CLK_HZ; i++) begin
      if (i == 3) begin
        submit = 1'b1;
        answer = expected;
      end
      step();
      submit = 1'b0;
      chk("rev_hold_state", 32'(o_state), 4);
      chk("rev_hold_sec",   32'(o_sec),   r % 60);
      if (i == 1) begin
        chk("rev_rv_low", 32'(o_rv), 0);
        chk("rev_rc_hold", 32'(o_rc), corr);
      end
    end
    step();
    if (m_round == rounds_n - 1) begin
      chk("done_state", 32'(o_state), 5);
      chk("done_flag",  32'(o_done),  1);
      chk("done_score", 32'(o_score), m_score);
      chk("done_rc",    32'(o_rc),    corr);
    end else begin
      m_round++;
      chk("next_state", 32'(o_state), 1);
      chk("next_round", 32'(o_round), m_round);
      step();
      chk("next_q_state", 32'(o_state), 2);
      chk("next_q_sec",   32'(o_sec),   TIME_SECS % 60);
      chk("next_q_rem",   32'(o_rem),   0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sa, pa, pl;
    bit rt;
    sel = 1'b0; start = 1'b0; submit = 1'b0; pause = 1'b0;
    answer = '0; expected = '0; reset = 1'b1;
    rounds_n = 2; score_max = 255;

    // Reset for two cycles, then start
    step(); chk_zero("rst1");
    step(); chk_zero("rst2");
    reset = 1'b0;
    begin_game();

    // Game 1: fast correct answer (+2), then a wrong answer with 1 s left
    play_round(9'h1A5, 3, 1'b1, 1000, 0);
    play_round(ANS_W'($urandom), 40, 1'b0, 1000, 0);
    submit = 1'b1; answer = expected;
    step();
    submit = 1'b0;
    chk("done_sub_state", 32'(o_state), 5);
    chk("done_sub_score", 32'(o_score), 2);
    chk("done_sub_done",  32'(o_done),  1);
    chk("done_sub_rv",    32'(o_rv),    0);
    begin_game();

    // Game 2: timeout, then a correct answer with 1 s left (+1)
    play_round(ANS_W'($urandom), -1, 1'b0, 1000, 0);
    play_round(ANS_W'($urandom), 45, 1'b1, 1000, 0);
    begin_game();

    // Game 3: submit on the expiring tick with a long pause, then a fast answer
    play_round(ANS_W'($urandom), 49, 1'b1, 20, 25);
    play_round(ANS_W'($urandom), 2, 1'b1, 1000, 0);

    // Randomised games
    repeat (3) begin
      begin_game();
      for (int r = 0; r < 2; r++) begin
        sa = $urandom_range(0, 60);
        if (sa > 52) sa = -1;
        rt = 1'($urandom_range(0, 1));
        pa = $urandom_range(0, 40);
        pl = $urandom_range(0, 20);
        play_round(ANS_W'($urandom), sa, rt, pa, pl);
      end
    end

    // Reset in the middle of QUESTION with a non-zero score
    begin_game();
    play_round(ANS_W'($urandom), 1, 1'b1, 1000, 0);
    step(); step(); step();
    reset = 1'b1; start = 1'b1; submit = 1'b1; answer = expected;
    step();
    reset = 1'b0; start = 1'b0; submit = 1'b0;
    chk_zero("midrst");
    submit = 1'b1;
    step();
    submit = 1'b0;
    chk("idle_sub_state", 32'(o_state), 0);
    chk("idle_sub_score", 32'(o_score), 0);

    // Instance B: 2-bit score saturates over three fast correct answers
    sel = 1'b1; rounds_n = 3; score_max = 3;
    begin_game();
    repeat (3) play_round(ANS_W'($urandom), $urandom_range(0, 8), 1'b1, 1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Parametrised round controller for the HexaQuiz game. It merges round sequencing and the per-question countdown into one block. It runs ROUNDS questions, each with a mm:ss countdown. Each submitted answer is compared against the expected value and a saturating score accumulates, with a time bonus for fast correct answers. It sits between the debounced key/switch inputs and the HEX/SoC display path, and its `state`, `minutes`, `seconds` and `rem` outputs feed that path.

## Interface
- CLK_HZ, 50_000_000, clock cycles per one-second tick
- ROUNDS, 8, questions per game (≥1)
- ANS_W, 9, answer/expected width
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1
- TIME_SECS, 60, per-question limit in seconds (1..3599)
- REVEAL_SECS, 2, result display hold in seconds (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; no other reset
- start  in  1  single-cycle pulse: begin/restart game
- submit  in  1  single-cycle pulse, already edge-detected upstream
- answer  in  ANS_W  player answer, sampled on accepted submit
- expected  in  ANS_W  correct answer for current round, stable during QUESTION
- pause  in  1  level; freezes all timing
- state  out  3  IDLE=0, LOAD=1, QUESTION=2, JUDGE=3, REVEAL=4, DONE=5
- round_idx  out  $clog2(ROUNDS) (min 1)  current round, 0-based
- minutes  out  6  remaining minutes
- seconds  out  6  remaining seconds 0..59
- rem  out  1  countdown expired in current round
- score  out  SCORE_W  accumulated score
- result_valid  out  1  one-cycle pulse on judgement
- result_correct  out  1  last judgement correct; held until next judgement
- done  out  1  game finished

## Operation
- Prescaler: counts 0..CLK_HZ-1. `tick` is asserted on the terminal count. The prescaler clears in IDLE, LOAD and JUDGE. It holds while `pause`=1.
- Remaining time is kept as mm:ss plus a parallel total-seconds counter, 12 bits wide. Both decrement together on `tick`. ss wraps 0→59 with an mm borrow.
- IDLE: all counters zero. `start` → LOAD. `submit` is ignored.
- LOAD, one cycle:
  - mm = TIME_SECS/60 and ss = TIME_SECS%60.
  - rem = 0.
  - Next state is QUESTION.
- QUESTION:
  - An accepted `submit` (requires `pause`=0) captures `answer==expected` and goes to JUDGE.
  - If a `tick` brings the time to 00:00 with no accepted submit, rem←1 and the block goes to JUDGE as a timeout (counts as incorrect).
  - If submit and the expiring tick arrive in the same cycle, the submit wins. The time still reaches 00:00, but rem stays 0.
- JUDGE, one cycle:
  - Correct with remaining total ≥ TIME_SECS/2 (integer division) adds +2.
  - Correct with less time remaining adds +1.
  - Incorrect or timeout adds 0.
  - The add saturates at 2^SCORE_W-1.
  - result_valid and result_correct take effect as the block enters REVEAL.
- REVEAL: holds for REVEAL_SECS ticks; `submit` is ignored; mm:ss are frozen. On the final tick:
  - if round_idx==ROUNDS-1, go to DONE;
  - otherwise round_idx+1 and go to LOAD.
- DONE: done=1, and all outputs hold. `start` → LOAD with score=0, round_idx=0, done=0 and result_correct=0.
- `start` outside IDLE and DONE is ignored.

## Timing
- Reset values: state=0, round_idx=0, minutes=0, seconds=0, rem=0, score=0, result_valid=0, result_correct=0, done=0. Prescaler=0.
- Reset mid-operation: IDLE and reset values on the next edge, regardless of other inputs.
- start at cycle N in IDLE → state=1 at N+1 → state=2 at N+2, with mm:ss loaded and visible from N+2.
- First tick comes CLK_HZ cycles after QUESTION entry, ignoring paused cycles.
- Accepted submit at N → state=3 at N+1 → at N+2: state=4, score updated, result_valid=1 for that one cycle.
- Timeout tick at N: seconds=0 and rem=1 at N+1, state=3 at N+1, result at N+2.
- All outputs are registered.

## Test plan
Parameters: CLK_HZ=10, TIME_SECS=5, REVEAL_SECS=1, ROUNDS=2, SCORE_W=8, ANS_W=9.

1. Reset for 2 cycles, then start. Required: all outputs 0 during reset; state 1 then 2; minutes=0, seconds=5, rem=0.
2. expected=0x1A5, answer=0x1A5, submit 3 cycles into QUESTION. Required: state=3, then state=4 with result_valid pulse, result_correct=1, score=2. After 10 cycles: round_idx=1, state 1→2, seconds=5.
3. Round 1, answer≠expected, submitted after 4 ticks (remaining 1). Required: score stays 2, result_correct=0. After REVEAL: state=5, done=1. A further submit changes nothing. start → score=0, round_idx=0, state 1→2.
4. No submit. Required: seconds steps 5,4,3,2,1,0, one step per 10 cycles. At 0: rem=1, state=3, then result_valid with result_correct=0 and score unchanged.
5. Correct answer with remaining=1 → +1. Submit coinciding with the expiring tick, correct → counted (+1), rem=0. pause=1 for 25 cycles mid-QUESTION → seconds frozen and submit ignored.
6. SCORE_W=2 with 3 correct fast answers → score 2, 3, 3 (saturation). Reset asserted mid-QUESTION → state=0 and score=0 the next cycle.
